// File: rtl/seq_mult8_pkg.sv
// Shared definitions for the iterative 8x8 multiplier.
//   - FSM state encoding (2 bits)
//   - step counter width
//   - per-step shift amounts and nibble-select masks
package seq_mult8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned STEP_W = 2;
  localparam logic [STEP_W-1:0] STEP_LAST = 2'd3;

  // Left shift applied to each 4x4 partial product, indexed by step.
  localparam logic [3:0] SHIFT_S0 = 4'd0;
  localparam logic [3:0] SHIFT_S1 = 4'd4;
  localparam logic [3:0] SHIFT_S2 = 4'd4;
  localparam logic [3:0] SHIFT_S3 = 4'd8;

  // Bit n set means "use the high nibble in step n".
  // Step order: lo*lo, hi*lo, lo*hi, hi*hi (factor1 * factor2).
  localparam logic [3:0] F1_HI_SEL = 4'b1010;
  localparam logic [3:0] F2_HI_SEL = 4'b1100;

  function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
    case (step)
      2'd0:    step_shift = SHIFT_S0;
      2'd1:    step_shift = SHIFT_S1;
      2'd2:    step_shift = SHIFT_S2;
      default: step_shift = SHIFT_S3;
    endcase
  endfunction

endpackage

// File: rtl/seq_mult8_cs4_fullbasecell.sv
// multiCS4_fullbasecell: combinational 4x4 unsigned multiplier.
// Partial-product rows are folded with 3:2 carry-save compression and a
// single carry-propagate add at the end.
//   a_i [3:0]  factor
//   b_i [3:0]  factor
//   p_o [7:0]  product a_i*b_i
module multiCS4_fullbasecell (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] s;
  logic [7:0] c;
  logic [7:0] r;
  logic [7:0] ns;
  logic [7:0] nc;

  always_comb begin
    s  = {4'b0000, a_i & {4{b_i[0]}}};
    c  = 8'h00;
    r  = 8'h00;
    ns = 8'h00;
    nc = 8'h00;
    for (int i = 1; i < 4; i++) begin
      r  = {4'b0000, a_i & {4{b_i[i]}}} << i;
      ns = s ^ c ^ r;
      nc = ((s & c) | (s & r) | (c & r)) << 1;
      s  = ns;
      c  = nc;
    end
    // Max 15*15 = 225, so the final 8-bit add cannot overflow.
    p_o = s + c;
  end

endmodule

// File: rtl/seq_mult8_cs4.sv
// seq_mult8_cs4: iterative 8x8 unsigned multiplier using one 4x4
// carry-save cell over four cycles, with valid/ready on both sides.
//   clk        clock
//   rst        synchronous active-high reset
//   factor1/2  [7:0] operands, captured on in_valid & in_ready
//   in_valid   operands present        in_ready  block can accept
//   product    [15:0] registered result, valid while out_valid
//   out_valid  result available        out_ready consumer accepts
//   busy       FSM not in IDLE
module seq_mult8_cs4
  import seq_mult8_pkg::*;
#(
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  factor1,
  input  logic [7:0]  factor2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  state_t              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [7:0]          f1_q;
  logic [7:0]          f2_q;
  logic [15:0]         acc_q;
  logic [15:0]         product_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [3:0]          nib1_d;
  logic [3:0]          nib2_d;
  logic [7:0]          pp_d;
  logic [15:0]         addend_d;
  logic [15:0]         sum_d;
  logic                zero_d;

  // Nibble selection comes from the captured operands only, so the
  // factor inputs never reach the datapath after the handshake.
  always_comb begin
    nib1_d   = F1_HI_SEL[step_q] ? f1_q[7:4] : f1_q[3:0];
    nib2_d   = F2_HI_SEL[step_q] ? f2_q[7:4] : f2_q[3:0];
    addend_d = {8'h00, pp_d} << step_shift(step_q);
    // Max total is 0xFE01, the 16-bit sum never carries out.
    sum_d    = acc_q + addend_d;
    zero_d   = (factor1 == 8'h00) || (factor2 == 8'h00);
  end

  multiCS4_fullbasecell u_cell (
    .a_i (nib1_d),
    .b_i (nib2_d),
    .p_o (pp_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      f1_q        <= '0;
      f2_q        <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            f1_q       <= factor1;
            f2_q       <= factor2;
            acc_q      <= '0;
            step_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (EARLY_ZERO && zero_d) begin
              product_q   <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          acc_q  <= sum_d;
          step_q <= step_q + 1'b1;
          if (step_q == STEP_LAST) begin
            product_q   <= sum_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // in_ready returns one cycle after the output handshake.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule
